// File: rtl/bullet_pool.sv
// bullet_pool: pool of independent bullets with per-slot latched direction, fire cooldown and opponent hit detection
module bullet_pool #(
  parameter int N_BULLETS = 4,
  parameter int COORD_W = 11,
  parameter int SCREEN_WIDTH = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int BULLET_SPEED = 1,
  parameter int SPRITE_W = 8,
  parameter int SPRITE_H = 8,
  parameter int COOLDOWN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic fire,
  input  logic [1:0] orientation,
  input  logic [COORD_W-1:0] sprite_x,
  input  logic [COORD_W-1:0] sprite_y,
  input  logic [COORD_W-1:0] opponent_x,
  input  logic [COORD_W-1:0] opponent_y,
  output logic fire_ack,
  output logic [N_BULLETS*COORD_W-1:0] bullet_x,
  output logic [N_BULLETS*COORD_W-1:0] bullet_y,
  output logic [N_BULLETS-1:0] bullet_active,
  output logic [N_BULLETS-1:0] hit_mask,
  output logic hit_opponent
);
  localparam int CD_W = COOLDOWN > 0 ? $clog2(COOLDOWN + 1) : 1;
  localparam int W = COORD_W + 1;
  localparam logic [W-1:0] SPD = W'(BULLET_SPEED);
  localparam logic [W-1:0] X_LIM = W'(SCREEN_WIDTH);
  localparam logic [W-1:0] Y_LIM = W'(SCREEN_HEIGHT);
  localparam logic [COORD_W-1:0] HALF_W = COORD_W'(SPRITE_W);
  localparam logic [COORD_W-1:0] HALF_H = COORD_W'(SPRITE_H);
  typedef enum logic {IDLE, ACTIVE} slot_t;
  slot_t state [N_BULLETS];
  slot_t state_n [N_BULLETS];
  logic [COORD_W-1:0] x [N_BULLETS];
  logic [COORD_W-1:0] y [N_BULLETS];
  logic [COORD_W-1:0] x_n [N_BULLETS];
  logic [COORD_W-1:0] y_n [N_BULLETS];
  logic [1:0] dir [N_BULLETS];
  logic [1:0] dir_n [N_BULLETS];
  logic [CD_W-1:0] cd, cd_n;
  logic [N_BULLETS-1:0] free, alloc, hits;
  logic [W-1:0] nx, ny;
  logic [COORD_W-1:0] dx, dy;
  logic move, oob, hit;

  for (genvar i = 0; i < N_BULLETS; i++) begin : g_out
    assign bullet_active[i] = state[i] == ACTIVE;
    assign bullet_x[i*COORD_W +: COORD_W] = x[i];
    assign bullet_y[i*COORD_W +: COORD_W] = y[i];
  end

  always_comb begin
    free = ~bullet_active;
    fire_ack = fire && cd == '0 && |free;
    // lowest set bit of the free mask picks the lowest-index idle slot
    alloc = fire_ack ? free & (~free + N_BULLETS'(1)) : '0;
    cd_n = fire_ack ? CD_W'(COOLDOWN) : tick && cd != '0 ? cd - CD_W'(1) : cd;
    hits = '0;
    nx = '0;
    ny = '0;
    dx = '0;
    dy = '0;
    move = 1'b0;
    oob = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < N_BULLETS; i++) begin
      state_n[i] = state[i];
      x_n[i] = x[i];
      y_n[i] = y[i];
      dir_n[i] = dir[i];
      move = tick && state[i] == ACTIVE;
      nx = dir[i] == 2'b00 ? {1'b0, x[i]} + SPD : dir[i] == 2'b10 ? {1'b0, x[i]} - SPD : {1'b0, x[i]};
      ny = dir[i] == 2'b01 ? {1'b0, y[i]} + SPD : dir[i] == 2'b11 ? {1'b0, y[i]} - SPD : {1'b0, y[i]};
      // left/up moves that would underflow retire instead of wrapping
      oob = (dir[i] == 2'b10 && {1'b0, x[i]} < SPD) || (dir[i] == 2'b11 && {1'b0, y[i]} < SPD) || nx >= X_LIM || ny >= Y_LIM;
      dx = nx[COORD_W-1:0] > opponent_x ? nx[COORD_W-1:0] - opponent_x : opponent_x - nx[COORD_W-1:0];
      dy = ny[COORD_W-1:0] > opponent_y ? ny[COORD_W-1:0] - opponent_y : opponent_y - ny[COORD_W-1:0];
      hit = dx < HALF_W && dy < HALF_H;
      hits[i] = move && !oob && hit;
      state_n[i] = alloc[i] ? ACTIVE : move && (oob || hit) ? IDLE : state[i];
      x_n[i] = alloc[i] ? sprite_x : move && !oob ? nx[COORD_W-1:0] : x[i];
      y_n[i] = alloc[i] ? sprite_y : move && !oob ? ny[COORD_W-1:0] : y[i];
      dir_n[i] = alloc[i] ? orientation : dir[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_BULLETS; i++) begin
        state[i] <= IDLE;
        x[i] <= '0;
        y[i] <= '0;
        dir[i] <= '0;
      end
      cd <= '0;
      hit_mask <= '0;
      hit_opponent <= 1'b0;
    end else begin
      for (int i = 0; i < N_BULLETS; i++) begin
        state[i] <= state_n[i];
        x[i] <= x_n[i];
        y[i] <= y_n[i];
        dir[i] <= dir_n[i];
      end
      cd <= cd_n;
      hit_mask <= hits;
      hit_opponent <= |hits;
    end
  end
endmodule
